// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: oversamples mdc/mdio, decodes frames and strobes a local register bank.
// Optional MDIO_PRE_SUPPRESS_EN: accept ST after a single idle 1 following a completed frame.
module mdio_slave #(
   parameter logic [4:0] PHY_ADDR = 5'h01,
   parameter int         PRE_LEN  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_t,
   output logic [4:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr_en,
   output logic        reg_rd_en,
   input  logic [15:0] reg_rdata,
   output logic        busy
);

   // Register bank handshake: reg_wr_en / reg_rd_en are single-clk strobes with no back-pressure;
   // reg_wdata/reg_addr are valid while reg_wr_en is high, reg_rdata is sampled 2 clk after reg_rd_en.

   typedef enum logic [2:0] {
      S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
   } state_t;

`ifdef MDIO_PRE_SUPPRESS_EN
   localparam logic PRE_SUPPRESS = 1'b1;
`else
   localparam logic PRE_SUPPRESS = 1'b0;
`endif

   localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

   logic       mdc_s1, mdc_s2, mdc_s3;
   logic       mdio_s1, mdio_s2;
   logic       rise_ev, fall_ev;
   logic       bit_in;

   state_t      state;
   logic [5:0]  pre_cnt;
   logic [3:0]  bcnt;
   logic        op_b0;
   logic        op_rd;
   logic        addr_match;
   logic        sup_ok;
   logic [4:0]  phy_sh;
   logic [4:0]  reg_sh;
   logic [15:0] wsh;

   logic        rd_act;
   logic [4:0]  fcnt;
   logic        rd_d1, rd_d2;
   logic [15:0] rd_sh;

   assign bit_in = mdio_s2;

   // Two-stage synchronizers plus registered edge detect: 3 clk from pin to event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_s1  <= 1'b0;
         mdc_s2  <= 1'b0;
         mdc_s3  <= 1'b0;
         mdio_s1 <= 1'b1;
         mdio_s2 <= 1'b1;
         rise_ev <= 1'b0;
         fall_ev <= 1'b0;
      end else begin
         mdc_s1  <= mdc;
         mdc_s2  <= mdc_s1;
         mdc_s3  <= mdc_s2;
         mdio_s1 <= mdio_i;
         mdio_s2 <= mdio_s1;
         rise_ev <= mdc_s2 & ~mdc_s3;
         fall_ev <= ~mdc_s2 & mdc_s3;
      end
   end

   // Frame decoder; every abort path clears the preamble count and the suppression credit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pre_cnt    <= 6'd0;
         bcnt       <= 4'd0;
         op_b0      <= 1'b0;
         op_rd      <= 1'b0;
         addr_match <= 1'b0;
         sup_ok     <= 1'b0;
         phy_sh     <= 5'd0;
         reg_sh     <= 5'd0;
         wsh        <= 16'd0;
         reg_addr   <= 5'd0;
         reg_wdata  <= 16'd0;
         reg_wr_en  <= 1'b0;
         reg_rd_en  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         if (state == S_DONE) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            pre_cnt <= 6'd0;
            sup_ok  <= PRE_SUPPRESS;
         end else if (rise_ev) begin
            case (state)
               S_IDLE: begin
                  if (bit_in) begin
                     if (sup_ok || pre_cnt == PRE_MAX) pre_cnt <= PRE_MAX;
                     else                              pre_cnt <= pre_cnt + 6'd1;
                  end else if (pre_cnt == PRE_MAX) begin
                     state   <= S_ST2;
                     busy    <= 1'b1;
                     pre_cnt <= 6'd0;
                  end else begin
                     pre_cnt <= 6'd0;
                     sup_ok  <= 1'b0;
                  end
               end
               S_ST2: begin
                  if (bit_in) begin
                     state <= S_OP;
                     bcnt  <= 4'd0;
                  end else begin
                     state   <= S_IDLE;
                     busy    <= 1'b0;
                     pre_cnt <= 6'd0;
                     sup_ok  <= 1'b0;
                  end
               end
               S_OP: begin
                  if (bcnt == 4'd0) begin
                     op_b0 <= bit_in;
                     bcnt  <= 4'd1;
                  end else if (op_b0 != bit_in) begin
                     op_rd <= op_b0;
                     state <= S_PHYAD;
                     bcnt  <= 4'd0;
                  end else begin
                     state   <= S_IDLE;
                     busy    <= 1'b0;
                     pre_cnt <= 6'd0;
                     sup_ok  <= 1'b0;
                     bcnt    <= 4'd0;
                  end
               end
               S_PHYAD: begin
                  phy_sh <= {phy_sh[3:0], bit_in};
                  if (bcnt == 4'd4) begin
                     state      <= S_REGAD;
                     bcnt       <= 4'd0;
                     addr_match <= ({phy_sh[3:0], bit_in} == PHY_ADDR);
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
               S_REGAD: begin
                  reg_sh <= {reg_sh[3:0], bit_in};
                  if (bcnt == 4'd4) begin
                     state <= S_TA;
                     bcnt  <= 4'd0;
                     if (addr_match && op_rd) begin
                        reg_addr  <= {reg_sh[3:0], bit_in};
                        reg_rd_en <= 1'b1;
                     end
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
               S_TA: begin
                  if (bcnt == 4'd1) begin
                     state <= S_DATA;
                     bcnt  <= 4'd0;
                  end else begin
                     bcnt <= 4'd1;
                  end
               end
               S_DATA: begin
                  wsh <= {wsh[14:0], bit_in};
                  if (bcnt == 4'd15) begin
                     state <= S_DONE;
                     bcnt  <= 4'd0;
                     if (addr_match && !op_rd) begin
                        reg_wdata <= {wsh[14:0], bit_in};
                        reg_addr  <= reg_sh;
                        reg_wr_en <= 1'b1;
                     end
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Read-data driver counts falls from the read strobe: fall 0 keeps TA1 released,
   // fall 1 drives TA2 low, falls 2..17 drive D15..D0, fall 18 releases the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdio_t <= 1'b1;
         mdio_o <= 1'b1;
         rd_act <= 1'b0;
         fcnt   <= 5'd0;
         rd_d1  <= 1'b0;
         rd_d2  <= 1'b0;
         rd_sh  <= 16'd0;
      end else begin
         rd_d1 <= reg_rd_en;
         rd_d2 <= rd_d1;
         if (reg_rd_en) begin
            rd_act <= 1'b1;
            fcnt   <= 5'd0;
         end else if (rd_d2) begin
            rd_sh <= reg_rdata;
         end else if (fall_ev && rd_act) begin
            fcnt <= fcnt + 5'd1;
            if (fcnt == 5'd1) begin
               mdio_t <= 1'b0;
               mdio_o <= 1'b0;
            end else if (fcnt >= 5'd2 && fcnt <= 5'd17) begin
               mdio_o <= rd_sh[15];
               rd_sh  <= {rd_sh[14:0], 1'b0};
            end else if (fcnt == 5'd18) begin
               mdio_t <= 1'b1;
               mdio_o <= 1'b1;
               rd_act <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave acting as the MDIO master (mdc half period = 4 clk).
module tb_mdio_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mdc = 1'b0;
   logic        m_drv = 1'b1;
   logic [15:0] rdata_val = 16'h0000;
   logic        mdio_o, mdio_t, mdio_line;
   logic [4:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr_en, reg_rd_en, busy;

   int tests = 0;
   int errors = 0;

   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, tlow_cnt = 0, busy_cnt = 0;
   logic [4:0]  wr_addr = 5'd0, rd_addr = 5'd0;
   logic [15:0] wr_data = 16'd0;
   logic        last_line, last_t;

   // Master releases the line by driving 1, standing in for the pull-up.
   assign mdio_line = mdio_t ? m_drv : mdio_o;

   always #5 clk = ~clk;

   mdio_slave #(.PHY_ADDR(5'h01), .PRE_LEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_line),
      .mdio_o(mdio_o), .mdio_t(mdio_t), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_rdata(rdata_val), .busy(busy)
   );

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_cnt  = wr_cnt + 1;
         wr_addr = reg_addr;
         wr_data = reg_wdata;
      end
      if (reg_rd_en) begin
         rd_cnt  = rd_cnt + 1;
         rd_addr = reg_addr;
      end
      if (reg_wr_en && reg_rd_en) both_cnt = both_cnt + 1;
      if (!mdio_t) tlow_cnt = tlow_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic mbit(input logic b);
      m_drv = b;
      #39;
      last_line = mdio_line;
      last_t    = mdio_t;
      #1 mdc = 1'b1;
      #40 mdc = 1'b0;
   endtask

   task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd, input int ndata,
                             output logic [15:0] rd, output logic [1:0] ta_line,
                             output logic [1:0] ta_t);
      logic is_rd;
      is_rd = (op == 2'b10);
      rd = 16'h0000;
      for (int i = 0; i < pre; i++) mbit(1'b1);
      mbit(1'b0); mbit(1'b1);
      mbit(op[1]); mbit(op[0]);
      for (int i = 4; i >= 0; i--) mbit(phy[i]);
      for (int i = 4; i >= 0; i--) mbit(ra[i]);
      mbit(1'b1);
      ta_line[1] = last_line; ta_t[1] = last_t;
      mbit(is_rd ? 1'b1 : 1'b0);
      ta_line[0] = last_line; ta_t[0] = last_t;
      for (int i = 0; i < ndata; i++) begin
         mbit(is_rd ? 1'b1 : wd[15-i]);
         rd[15-i] = last_line;
      end
      m_drv = 1'b1;
   endtask

   task automatic test_reset;
      #3;
      tests++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL reset_mdio_t got %b exp 1", mdio_t); end
      tests++; if (mdio_o !== 1'b1) begin errors++; $display("FAIL reset_mdio_o got %b exp 1", mdio_o); end
      tests++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", reg_wr_en); end
      tests++; if (reg_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", reg_rd_en); end
      tests++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 00", reg_addr); end
      tests++; if (reg_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0000", reg_wdata); end
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      #7;
   endtask

   task automatic test_write;
      int w0, r0, t0;
      logic [15:0] rd; logic [1:0] tl, tt;
      w0 = wr_cnt; r0 = rd_cnt; t0 = tlow_cnt;
      send_frame(32, 2'b01, 5'h01, 5'h05, 16'hA5C3, 16, rd, tl, tt);
      #40;
      tests++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_count got %0d exp 1", wr_cnt - w0); end
      tests++; if (wr_addr !== 5'h05) begin errors++; $display("FAIL write_addr got %h exp 05", wr_addr); end
      tests++; if (wr_data !== 16'hA5C3) begin errors++; $display("FAIL write_data got %h exp a5c3", wr_data); end
      tests++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL write_no_rd got %0d exp 0", rd_cnt - r0); end
      tests++; if (tlow_cnt - t0 !== 0) begin errors++; $display("FAIL write_bus_released got %0d low cycles exp 0", tlow_cnt - t0); end
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b exp 0", busy); end
   endtask

   task automatic test_read;
      int w0, r0;
      logic [15:0] rd; logic [1:0] tl, tt;
      w0 = wr_cnt; r0 = rd_cnt;
      rdata_val = 16'h1234;
      send_frame(32, 2'b10, 5'h01, 5'h02, 16'h0000, 16, rd, tl, tt);
      mbit(1'b1);
      tests++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_count got %0d exp 1", rd_cnt - r0); end
      tests++; if (rd_addr !== 5'h02) begin errors++; $display("FAIL read_addr got %h exp 02", rd_addr); end
      tests++; if (tt[1] !== 1'b1) begin errors++; $display("FAIL read_ta1_z got mdio_t=%b exp 1", tt[1]); end
      tests++; if ({tt[0], tl[0]} !== 2'b00) begin errors++; $display("FAIL read_ta2_zero got t=%b line=%b exp 0 0", tt[0], tl[0]); end
      tests++; if (rd !== 16'h1234) begin errors++; $display("FAIL read_data got %h exp 1234", rd); end
      tests++; if (last_t !== 1'b1) begin errors++; $display("FAIL read_release got mdio_t=%b exp 1", last_t); end
      tests++; if (wr_cnt - w0 !== 0 || both_cnt !== 0) begin errors++; $display("FAIL read_no_wr got wr=%0d both=%0d exp 0 0", wr_cnt - w0, both_cnt); end
   endtask

   task automatic test_phy_mismatch;
      int w0, r0, t0;
      logic [15:0] rd; logic [1:0] tl, tt;
      w0 = wr_cnt; r0 = rd_cnt; t0 = tlow_cnt;
      send_frame(32, 2'b01, 5'h03, 5'h05, 16'hFFFF, 16, rd, tl, tt);
      send_frame(32, 2'b10, 5'h03, 5'h02, 16'h0000, 16, rd, tl, tt);
      #40;
      tests++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL mismatch_strobes got wr=%0d rd=%0d exp 0 0", wr_cnt - w0, rd_cnt - r0); end
      tests++; if (tlow_cnt - t0 !== 0) begin errors++; $display("FAIL mismatch_released got %0d low cycles exp 0", tlow_cnt - t0); end
      tests++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL mismatch_line got %h exp ffff", rd); end
      send_frame(32, 2'b01, 5'h01, 5'h07, 16'h0F0F, 16, rd, tl, tt);
      #40;
      tests++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL mismatch_next_count got %0d exp 1", wr_cnt - w0); end
      tests++; if (wr_addr !== 5'h07 || wr_data !== 16'h0F0F) begin errors++; $display("FAIL mismatch_next_data got %h/%h exp 07/0f0f", wr_addr, wr_data); end
   endtask

   task automatic test_abort_and_short_preamble;
      int w0, r0, b0;
      logic [15:0] rd; logic [1:0] tl, tt;
      w0 = wr_cnt; r0 = rd_cnt; b0 = busy_cnt;
      for (int i = 0; i < 32; i++) mbit(1'b1);
      mbit(1'b0); mbit(1'b1); mbit(1'b1); mbit(1'b1);
      #40;
      tests++; if (busy_cnt - b0 <= 0) begin errors++; $display("FAIL abort_busy_seen got %0d cycles exp >0", busy_cnt - b0); end
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_fall got %b exp 0", busy); end
      tests++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL abort_strobes got wr=%0d rd=%0d exp 0 0", wr_cnt - w0, rd_cnt - r0); end
      send_frame(31, 2'b01, 5'h01, 5'h05, 16'hA5C3, 16, rd, tl, tt);
      #40;
      tests++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL short_pre_ignored got %0d writes exp 0", wr_cnt - w0); end
      tests++; if (busy_cnt - b0 > 40) begin errors++; $display("FAIL short_pre_busy got %0d busy cycles exp <=40", busy_cnt - b0); end
   endtask

   task automatic test_back_to_back;
      int w0;
      logic [15:0] rd; logic [1:0] tl, tt;
      w0 = wr_cnt;
      send_frame(32, 2'b01, 5'h01, 5'h0A, 16'h1111, 16, rd, tl, tt);
      mbit(1'b1);
      send_frame(0, 2'b01, 5'h01, 5'h0B, 16'h2222, 16, rd, tl, tt);
      #40;
`ifdef MDIO_PRE_SUPPRESS_EN
      tests++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", wr_cnt - w0); end
      tests++; if (wr_addr !== 5'h0B || wr_data !== 16'h2222) begin errors++; $display("FAIL b2b_last got %h/%h exp 0b/2222", wr_addr, wr_data); end
`else
      tests++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL b2b_count got %0d exp 1", wr_cnt - w0); end
      tests++; if (wr_addr !== 5'h0A || wr_data !== 16'h1111) begin errors++; $display("FAIL b2b_last got %h/%h exp 0a/1111", wr_addr, wr_data); end
`endif
      tests++; if (both_cnt !== 0) begin errors++; $display("FAIL b2b_both got %0d exp 0", both_cnt); end
   endtask

   task automatic test_reset_mid_read;
      int r0;
      logic [15:0] rd; logic [1:0] tl, tt;
      rdata_val = 16'h1234;
      send_frame(32, 2'b10, 5'h01, 5'h04, 16'h0000, 7, rd, tl, tt);
      #60;
      tests++; if ({mdio_t, mdio_o} !== 2'b00) begin errors++; $display("FAIL midread_driving_d8 got t=%b o=%b exp 0 0", mdio_t, mdio_o); end
      tests++; if (rd[15:9] !== 7'b0001001) begin errors++; $display("FAIL midread_upper_bits got %b exp 0001001", rd[15:9]); end
      #2 rst_n = 1'b0;
      #2;
      tests++; if (mdio_t !== 1'b1 || mdio_o !== 1'b1) begin errors++; $display("FAIL midread_async_release got t=%b o=%b exp 1 1", mdio_t, mdio_o); end
      tests++; if ({reg_wr_en, reg_rd_en, busy} !== 3'b000) begin errors++; $display("FAIL midread_strobes got %b exp 000", {reg_wr_en, reg_rd_en, busy}); end
      tests++; if (reg_addr !== 5'd0 || reg_wdata !== 16'd0) begin errors++; $display("FAIL midread_regs got %h/%h exp 00/0000", reg_addr, reg_wdata); end
      #26 rst_n = 1'b1;
      #10;
      r0 = rd_cnt;
      rdata_val = 16'hBEEF;
      send_frame(32, 2'b10, 5'h01, 5'h1F, 16'h0000, 16, rd, tl, tt);
      mbit(1'b1);
      tests++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL post_reset_read_data got %h exp beef", rd); end
      tests++; if (rd_cnt - r0 !== 1 || rd_addr !== 5'h1F) begin errors++; $display("FAIL post_reset_read_strobe got %0d/%h exp 1/1f", rd_cnt - r0, rd_addr); end
      tests++; if (last_t !== 1'b1) begin errors++; $display("FAIL post_reset_release got %b exp 1", last_t); end
   endtask

   initial begin
      #50 rst_n = 1'b1;
      #20;
      test_reset;
      test_write;
      test_read;
      test_phy_mismatch;
      test_abort_and_short_preamble;
      test_back_to_back;
      test_reset_mid_read;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog got timeout exp completion");
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $fatal(1, "watchdog");
   end

endmodule
